display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's common-anode multi-digit seven-segment display.
- Shares a single hex-to-seven-segment decoder between N_DIGITS digits. It does this by steering one 4-bit nibble to the decoder input and enabling exactly one active-low anode at a time.
- Holds a shadow copy of the displayed value. New values are accepted through a req/ack handshake, only at frame boundaries, so no tearing is visible.
- Optionally blanks leading zeros.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, dwell time per digit in clk cycles (>= 3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- data_i  in  4*N_DIGITS  value to display; nibble k drives digit k; digit 0 is least significant.
- upd_req_i  in  1  level request to load data_i into the shadow register. Held high until upd_ack_o; data_i stable while high.
- upd_ack_o  out  1  one-cycle pulse: data_i captured this cycle.
- en_i  in  1  scan enable; 0 turns the display off.
- lz_blank_i  in  1  1 = blank leading zeros.
- bcd_o  out  4  nibble to the shared decoder.
- an_o  out  N_DIGITS  anode enables, active-low, at most one bit low.
- blank_o  out  1  1 = segment outputs must be forced off (all segments high).
- frame_o  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - shadow=0, div=0, idx=0, pending=0.
  - an_o all 1, bcd_o=0, blank_o=1, upd_ack_o=0, frame_o=0.
  - Reset mid-frame aborts the scan and drops any pending request. A still-high upd_req_i is re-captured normally afterwards.
- All outputs are registered.
- States: OFF, GAP, SHOW.
- OFF:
  - Entered from reset, or from any state when en_i=0.
  - an_o all 1, blank_o=1; div and idx held at 0.
  - If en_i=1: go to GAP with idx=0.
- GAP (one cycle, anti-ghosting):
  - an_o all 1, blank_o=1.
  - bcd_o loads shadow nibble idx.
  - Next state SHOW with div=0.
- SHOW:
  - an_o = ~(1<<idx), unless digit idx is blanked.
  - bcd_o = shadow nibble idx.
  - div increments each cycle.
  - At div=REFRESH_DIV-2: go to GAP and advance idx = (idx+1) mod N_DIGITS. Total per-digit period including GAP = REFRESH_DIV cycles.
  - When idx wraps N_DIGITS-1 -> 0: frame_o=1 for that cycle (the frame boundary).
- Leading-zero blanking:
  - Digit k>0 is blanked when lz_blank_i=1 and shadow nibbles N_DIGITS-1..k are all 0.
  - Digit 0 is never blanked.
  - A blanked digit gives an_o all 1 and blank_o=1 for its full dwell; the scan timing is unchanged.
  - lz_blank_i is evaluated combinationally against the shadow each cycle.
- Update handshake:
  - upd_req_i=1 sets pending. The first cycle of upd_req_i high sets pending; it does not capture.
  - At a frame boundary with pending=1: shadow<=data_i, upd_ack_o=1 in the same cycle, pending cleared.
  - In OFF: capture occurs on the cycle after pending is set.
  - Requester must drop upd_req_i the cycle after ack. A request still high 1 cycle after ack is treated as a new request.
- en_i falling mid-dwell: next cycle is OFF with an_o all 1. No frame_o pulse. Pending request is serviced per the OFF rule.
- Simultaneous frame boundary and first cycle of upd_req_i: pending is set only; capture at the next boundary.

Test Plan (N_DIGITS=4, REFRESH_DIV=4):
- Reset then en_i=1, shadow 0 -> an_o sequence 1111 (GAP), 1110 ×3, 1111, 1101 ×3, …; frame_o pulses every 16 cycles; bcd_o=0 throughout.
- upd_req_i=1 with data_i=16'h12AF mid-frame -> no change until boundary. Then upd_ack_o one pulse, frame_o same cycle; next frame shows bcd_o F, A, 2, 1 on digits 0..3.
- shadow=16'h0070, lz_blank_i=1 -> digits 3 and 2 have an_o=1111 and blank_o=1; digit 1 shows 7; digit 0 shows 0. With lz_blank_i=0 all four digits are lit.
- shadow=0, lz_blank_i=1 -> only digit 0 lit (shows 0).
- en_i=0 during digit 2 -> an_o=1111 and blank_o=1 the next cycle. Re-enable -> GAP then digit 0 with a full dwell.
- rst_n=0 for 1 cycle while pending=1 -> no ack; all outputs return to reset values. upd_req_i still high -> ack at the first frame boundary after reset.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   data_i        - value to show, nibble k -> digit k (digit 0 = LSD)
//   upd_req_i     - level request to load data_i into the shadow register
//   upd_ack_o     - one-cycle pulse, data_i captured this cycle
//   en_i          - scan enable, 0 turns the display off
//   lz_blank_i    - blank leading zeros
//   bcd_o         - nibble for the shared hex decoder
//   an_o          - active-low anode enables, at most one low
//   blank_o       - force all segments off
//   frame_o       - one-cycle pulse at each frame boundary
module display_scan_ctrl #(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] data_i,
   input  logic                  upd_req_i,
   output logic                  upd_ack_o,
   input  logic                  en_i,
   input  logic                  lz_blank_i,
   output logic [3:0]            bcd_o,
   output logic [N_DIGITS-1:0]   an_o,
   output logic                  blank_o,
   output logic                  frame_o
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   typedef enum logic [1:0] {S_OFF, S_GAP, S_SHOW} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DIV_W-1:0]      r_div;
   logic [DIV_W-1:0]      w_div_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [4*N_DIGITS-1:0] r_shadow;
   logic [4*N_DIGITS-1:0] w_shadow_nxt;
   logic                  r_pending;
   logic                  w_pending_nxt;
   logic                  r_ack;
   logic                  r_frame;
   logic                  r_blank;
   logic [3:0]            r_bcd;
   logic [N_DIGITS-1:0]   r_an;
   logic                  w_boundary;
   logic                  w_capture;
   logic                  w_zero_acc;
   logic                  w_lz_hide;
   logic                  w_lit;
   logic [3:0]            w_nib;

   // Scan sequencing: GAP (1 cycle) then SHOW (REFRESH_DIV-1 cycles)
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_idx_nxt   = r_idx;
      w_boundary  = 1'b0;
      if (!en_i) begin
         w_state_nxt = S_OFF;
         w_div_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         unique case (r_state)
            S_OFF: begin
               w_state_nxt = S_GAP;
               w_div_nxt   = '0;
               w_idx_nxt   = '0;
            end
            S_GAP: begin
               w_state_nxt = S_SHOW;
               w_div_nxt   = '0;
            end
            S_SHOW: begin
               if (r_div == DIV_LAST) begin
                  w_state_nxt = S_GAP;
                  w_div_nxt   = '0;
                  if (r_idx == IDX_LAST) begin
                     w_idx_nxt  = '0;
                     w_boundary = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx + 1'b1;
                  end
               end else begin
                  w_div_nxt = r_div + 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_OFF;
               w_div_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // Shadow update, and per-digit output selection for the next cycle.
   // A request seen during the ack cycle is the one just served.
   always_comb begin
      w_capture     = r_pending & (w_boundary | (r_state == S_OFF));
      w_shadow_nxt  = w_capture ? data_i : r_shadow;
      w_pending_nxt = w_capture ? 1'b0
                                : (r_pending | (upd_req_i & ~r_ack));
      w_nib         = w_shadow_nxt[4*int'(w_idx_nxt) +: 4];
      // Walk down from the MSD; a digit hides while all above are zero
      w_zero_acc    = 1'b1;
      w_lz_hide     = 1'b0;
      for (int k = N_DIGITS - 1; k > 0; k--) begin
         w_zero_acc = w_zero_acc & (w_shadow_nxt[4*k +: 4] == 4'd0);
         if (int'(w_idx_nxt) == k) w_lz_hide = w_zero_acc;
      end
      w_lz_hide = w_lz_hide & lz_blank_i;
      w_lit     = (w_state_nxt == S_SHOW) & ~w_lz_hide;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_OFF;
         r_div     <= '0;
         r_idx     <= '0;
         r_shadow  <= '0;
         r_pending <= 1'b0;
         r_ack     <= 1'b0;
         r_frame   <= 1'b0;
         r_blank   <= 1'b1;
         r_bcd     <= 4'd0;
         r_an      <= '1;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_idx     <= w_idx_nxt;
         r_shadow  <= w_shadow_nxt;
         r_pending <= w_pending_nxt;
         r_ack     <= w_capture;
         r_frame   <= w_boundary;
         r_blank   <= ~w_lit;
         r_bcd     <= w_nib;
         r_an      <= w_lit ? ~(N_DIGITS'(1) << w_idx_nxt) : '1;
      end
   end

   assign upd_ack_o = r_ack;
   assign frame_o   = r_frame;
   assign blank_o   = r_blank;
   assign bcd_o     = r_bcd;
   assign an_o      = r_an;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (N_DIGITS=4, REFRESH_DIV=4).
// Table of per-cycle vectors plus hand sequences for corner cases.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_i;
   logic        upd_req_i;
   logic        upd_ack_o;
   logic        en_i;
   logic        lz_blank_i;
   logic [3:0]  bcd_o;
   logic [3:0]  an_o;
   logic        blank_o;
   logic        frame_o;

   int n_tests = 0;
   int n_fail  = 0;

   display_scan_ctrl #(
      .N_DIGITS   (4),
      .REFRESH_DIV(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_i    (data_i),
      .upd_req_i (upd_req_i),
      .upd_ack_o (upd_ack_o),
      .en_i      (en_i),
      .lz_blank_i(lz_blank_i),
      .bcd_o     (bcd_o),
      .an_o      (an_o),
      .blank_o   (blank_o),
      .frame_o   (frame_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          rep;
      logic        en;
      logic        req;
      logic [15:0] data;
      logic [3:0]  an;
      logic [3:0]  bcd;
      logic        blank;
      logic        frame;
      logic        ack;
   } vec_t;

   vec_t tbl[$];

   function automatic void v(input int rep, input logic en,
                             input logic req, input logic [15:0] data,
                             input logic [3:0] an, input logic [3:0] bcd,
                             input logic blank, input logic frame,
                             input logic ack);
      vec_t t;
      t.rep = rep; t.en = en; t.req = req; t.data = data;
      t.an = an; t.bcd = bcd; t.blank = blank;
      t.frame = frame; t.ack = ack;
      tbl.push_back(t);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [3:0] an,
                        input logic [3:0] bcd, input bit cb,
                        input logic blk, input logic fr,
                        input logic ack);
      n_tests++;
      if (an_o !== an || (cb && bcd_o !== bcd) || blank_o !== blk ||
          frame_o !== fr || upd_ack_o !== ack) begin
         n_fail++;
         $display("FAIL %s: got an=%b bcd=%h blank=%b frame=%b ack=%b, want an=%b bcd=%h(%0d) blank=%b frame=%b ack=%b",
                  nm, an_o, bcd_o, blank_o, frame_o, upd_ack_o,
                  an, bcd, cb, blk, fr, ack);
      end
   endtask

   // One digit: GAP cycle then three SHOW cycles
   task automatic scan_digit(input string nm, input logic [3:0] an,
                             input logic [3:0] bcd, input logic blk,
                             input logic fr, input logic ack);
      step();
      check({nm, "_gap"}, 4'hF, bcd, 1'b1, 1'b1, fr, ack);
      repeat (3) begin
         step();
         check(nm, blk ? 4'hF : an, bcd, 1'b1, blk, 1'b0, 1'b0);
      end
   endtask

   // Drop enable and load a value through the OFF capture path
   task automatic load_off(input logic [15:0] d);
      en_i = 1'b0; upd_req_i = 1'b1; data_i = d;
      step();
      check("off_enter", 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      check("off_ack", 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      upd_req_i = 1'b0;
      step();
      check("off_post", 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; en_i = 1'b0; upd_req_i = 1'b0;
      lz_blank_i = 1'b0; data_i = 16'h0;

      // Scan with shadow 0, then mid-frame update to 12AF
      v(1, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
      v(3, 1, 0, 16'h0000, 4'hE, 4'h0, 0, 0, 0);
      v(1, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
      v(3, 1, 0, 16'h0000, 4'hD, 4'h0, 0, 0, 0);
      v(1, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
      v(3, 1, 0, 16'h0000, 4'hB, 4'h0, 0, 0, 0);
      v(1, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
      v(3, 1, 0, 16'h0000, 4'h7, 4'h0, 0, 0, 0);
      v(1, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 1, 0);
      v(1, 1, 0, 16'h0000, 4'hE, 4'h0, 0, 0, 0);
      v(2, 1, 1, 16'h12AF, 4'hE, 4'h0, 0, 0, 0);
      v(1, 1, 1, 16'h12AF, 4'hF, 4'h0, 1, 0, 0);
      v(3, 1, 1, 16'h12AF, 4'hD, 4'h0, 0, 0, 0);
      v(1, 1, 1, 16'h12AF, 4'hF, 4'h0, 1, 0, 0);
      v(3, 1, 1, 16'h12AF, 4'hB, 4'h0, 0, 0, 0);
      v(1, 1, 1, 16'h12AF, 4'hF, 4'h0, 1, 0, 0);
      v(3, 1, 1, 16'h12AF, 4'h7, 4'h0, 0, 0, 0);
      v(1, 1, 1, 16'h12AF, 4'hF, 4'hF, 1, 1, 1);
      v(1, 1, 1, 16'h12AF, 4'hE, 4'hF, 0, 0, 0);
      v(2, 1, 0, 16'h12AF, 4'hE, 4'hF, 0, 0, 0);
      v(1, 1, 0, 16'h12AF, 4'hF, 4'hA, 1, 0, 0);
      v(3, 1, 0, 16'h12AF, 4'hD, 4'hA, 0, 0, 0);
      v(1, 1, 0, 16'h12AF, 4'hF, 4'h2, 1, 0, 0);
      v(3, 1, 0, 16'h12AF, 4'hB, 4'h2, 0, 0, 0);
      v(1, 1, 0, 16'h12AF, 4'hF, 4'h1, 1, 0, 0);
      v(3, 1, 0, 16'h12AF, 4'h7, 4'h1, 0, 0, 0);
      v(1, 1, 0, 16'h12AF, 4'hF, 4'hF, 1, 1, 0);

      // Reset state
      step();
      step();
      check("reset", 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].rep; r++) begin
            en_i = tbl[i].en; upd_req_i = tbl[i].req;
            data_i = tbl[i].data;
            step();
            check($sformatf("vec%0d.%0d", i, r), tbl[i].an, tbl[i].bcd,
                  1'b1, tbl[i].blank, tbl[i].frame, tbl[i].ack);
         end
      end

      // Leading-zero blanking with shadow 0070
      load_off(16'h0070);
      lz_blank_i = 1'b1; en_i = 1'b1;
      scan_digit("lz70_d0", 4'hE, 4'h0, 1'b0, 1'b0, 1'b0);
      scan_digit("lz70_d1", 4'hD, 4'h7, 1'b0, 1'b0, 1'b0);
      scan_digit("lz70_d2", 4'hB, 4'h0, 1'b1, 1'b0, 1'b0);
      scan_digit("lz70_d3", 4'h7, 4'h0, 1'b1, 1'b0, 1'b0);
      scan_digit("lz70_d0b", 4'hE, 4'h0, 1'b0, 1'b1, 1'b0);
      lz_blank_i = 1'b0;
      scan_digit("nolz_d1", 4'hD, 4'h7, 1'b0, 1'b0, 1'b0);
      scan_digit("nolz_d2", 4'hB, 4'h0, 1'b0, 1'b0, 1'b0);
      scan_digit("nolz_d3", 4'h7, 4'h0, 1'b0, 1'b0, 1'b0);

      // Shadow 0 with blanking: only digit 0 lit
      load_off(16'h0000);
      lz_blank_i = 1'b1; en_i = 1'b1;
      scan_digit("lz0_d0", 4'hE, 4'h0, 1'b0, 1'b0, 1'b0);
      scan_digit("lz0_d1", 4'hD, 4'h0, 1'b1, 1'b0, 1'b0);
      scan_digit("lz0_d2", 4'hB, 4'h0, 1'b1, 1'b0, 1'b0);
      scan_digit("lz0_d3", 4'h7, 4'h0, 1'b1, 1'b0, 1'b0);
      scan_digit("lz0_d0b", 4'hE, 4'h0, 1'b0, 1'b1, 1'b0);

      // Disable during digit 2, then re-enable
      lz_blank_i = 1'b0;
      scan_digit("en_d1", 4'hD, 4'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("en_d2_gap", 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check("en_d2", 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      en_i = 1'b0;
      step();
      check("en_off", 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      en_i = 1'b1;
      scan_digit("reen_d0", 4'hE, 4'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("reen_d1_gap", 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Reset while a request is pending
      upd_req_i = 1'b1; data_i = 16'h4321;
      step();
      check("rq_pend", 4'hD, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      step();
      check("rq_reset", 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      scan_digit("rr_d0", 4'hE, 4'h0, 1'b0, 1'b0, 1'b0);
      scan_digit("rr_d1", 4'hD, 4'h0, 1'b0, 1'b0, 1'b0);
      scan_digit("rr_d2", 4'hB, 4'h0, 1'b0, 1'b0, 1'b0);
      scan_digit("rr_d3", 4'h7, 4'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("rr_ack", 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1);
      upd_req_i = 1'b0;
      repeat (3) begin
         step();
         check("rr_show", 4'hE, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      step();
      check("rr_d1_gap", 4'hF, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
